// File: rtl/reorder_buffer_pkg.sv
// reorder_buffer_pkg -- shared types and helpers for the reorder buffer.
//   ROB_DEPTH / ROB_TAG_W : entry count (power of two) and rename tag width
//   rob_entry_t           : one ROB slot
//   flush_reason_e        : why the ROB asked for a pipeline flush
//   is_mispredict()       : retiring branch whose outcome differs from the guess
//   redirect_pc()         : correct fetch PC after a mispredicted branch
package reorder_buffer_pkg;

    localparam int ROB_DEPTH = 16;
    localparam int ROB_TAG_W = $clog2(ROB_DEPTH);
    localparam int XLEN      = 32;
    localparam int REG_W     = 5;

    typedef enum logic [1:0] {
        FLUSH_NONE          = 2'd0,
        FLUSH_BR_MISPREDICT = 2'd1
    } flush_reason_e;

    typedef struct packed {
        logic             busy;
        logic             ready;
        logic [REG_W-1:0] dest;
        logic [XLEN-1:0]  pc;
        logic [XLEN-1:0]  value;   // result; branch bit0 = taken; jalr target
        logic [XLEN-1:0]  target;  // branch taken-target
        logic             is_branch;
        logic             is_jalr;
        logic             pred_jump;
    } rob_entry_t;

    function automatic logic is_mispredict(input rob_entry_t e);
        return e.is_branch && (e.value[0] != e.pred_jump);
    endfunction

    function automatic logic [XLEN-1:0] redirect_pc(input rob_entry_t e);
        return e.value[0] ? e.target : e.pc + 32'd4;
    endfunction

endpackage

// File: rtl/reorder_buffer_if.sv
// reorder_buffer_if -- issue, writeback, operand query, commit and flush
// signals between the pipeline and the reorder buffer.
//   master : decode/issue, ALU, LSB and cdb side (drives issue/wb/query)
//   slave  : the reorder buffer (drives rename, full, query results, commit, flush)
interface reorder_buffer_if
    import reorder_buffer_pkg::*;
#(
    parameter int TAG_W = ROB_TAG_W
);
    // issue
    logic             issue_valid;
    logic [REG_W-1:0] issue_dest;
    logic [XLEN-1:0]  issue_pc;
    logic             issue_is_branch;
    logic             issue_is_jalr;
    logic             issue_pred_jump;
    logic [TAG_W-1:0] issue_rename;
    logic             rob_full;
    // writeback
    logic             alu_wb_valid;
    logic [TAG_W-1:0] alu_wb_rename;
    logic [XLEN-1:0]  alu_wb_value;
    logic [XLEN-1:0]  alu_wb_target;
    logic             lsb_wb_valid;
    logic [TAG_W-1:0] lsb_wb_rename;
    logic [XLEN-1:0]  lsb_wb_value;
    // operand query
    logic [TAG_W-1:0] query_rename_a;
    logic [TAG_W-1:0] query_rename_b;
    logic             query_ready_a;
    logic             query_ready_b;
    logic [XLEN-1:0]  query_value_a;
    logic [XLEN-1:0]  query_value_b;
    // commit / flush
    logic             commit_flag;
    logic [XLEN-1:0]  commit_value;
    logic [TAG_W-1:0] commit_rename;
    logic [REG_W-1:0] commit_dest;
    logic             commit_is_branch;
    logic             commit_is_jalr;
    logic [XLEN-1:0]  jalr_next_pc;
    logic             cdb_flush;
    logic [XLEN-1:0]  flush_pc;

    modport master (
        output issue_valid, issue_dest, issue_pc, issue_is_branch, issue_is_jalr, issue_pred_jump,
        output alu_wb_valid, alu_wb_rename, alu_wb_value, alu_wb_target,
        output lsb_wb_valid, lsb_wb_rename, lsb_wb_value,
        output query_rename_a, query_rename_b,
        input  issue_rename, rob_full, query_ready_a, query_ready_b, query_value_a, query_value_b,
        input  commit_flag, commit_value, commit_rename, commit_dest, commit_is_branch,
        input  commit_is_jalr, jalr_next_pc, cdb_flush, flush_pc
    );

    modport slave (
        input  issue_valid, issue_dest, issue_pc, issue_is_branch, issue_is_jalr, issue_pred_jump,
        input  alu_wb_valid, alu_wb_rename, alu_wb_value, alu_wb_target,
        input  lsb_wb_valid, lsb_wb_rename, lsb_wb_value,
        input  query_rename_a, query_rename_b,
        output issue_rename, rob_full, query_ready_a, query_ready_b, query_value_a, query_value_b,
        output commit_flag, commit_value, commit_rename, commit_dest, commit_is_branch,
        output commit_is_jalr, jalr_next_pc, cdb_flush, flush_pc
    );

endinterface

// File: rtl/reorder_buffer_ptr_ctrl.sv
// reorder_buffer_ptr_ctrl -- head/tail/count bookkeeping for the ROB ring.
//   clk, rst          : clock, synchronous active-high reset
//   rdy               : global enable, 0 holds all pointers
//   do_issue/do_commit: allocate at tail / retire at head this edge
//   flush             : empty the ring (head=tail=count=0), wins over issue/commit
//   head, tail, count : ring state; full / empty decoded from count
module reorder_buffer_ptr_ctrl #(
    parameter int DEPTH = 16,
    parameter int TAG_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             do_issue,
    input  logic             do_commit,
    input  logic             flush,
    output logic [TAG_W-1:0] head,
    output logic [TAG_W-1:0] tail,
    output logic [TAG_W:0]   count,
    output logic             full,
    output logic             empty
);

    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (rdy) begin
            if (flush) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                // DEPTH is a power of two, so the pointers wrap naturally
                if (do_issue)  tail <= tail + 1'b1;
                if (do_commit) head <= head + 1'b1;
                count <= count + (TAG_W+1)'(do_issue) - (TAG_W+1)'(do_commit);
            end
        end
    end

    assign full  = (count == (TAG_W+1)'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/reorder_buffer.sv
// reorder_buffer -- 16-entry circular ROB: allocates rename tags at issue,
// captures ALU/LSB writebacks, retires the head in program order and raises a
// one-cycle cdb_flush after a mispredicted branch retires.
//   clk, rst : clock, synchronous active-high reset (beats rdy)
//   rdy      : global enable; 0 freezes state and clears commit_flag/cdb_flush
//   rob      : reorder_buffer_if.slave (issue, writeback, query, commit, flush)
// Build option: ROB_WB_BYPASS_EN -- a writeback hitting the head tag retires
// on that same edge using the writeback bus value.
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int DEPTH = ROB_DEPTH,
    parameter int TAG_W = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rdy,
    reorder_buffer_if.slave    rob
);

    rob_entry_t       ent [DEPTH];
    logic [TAG_W-1:0] head, tail;
    logic [TAG_W:0]   count;
    logic             ptr_full, ptr_empty;
    logic             flush_pending;
    rob_entry_t       head_ent;     // head as it would retire this edge
    logic             do_commit, do_issue, mispredict, wb_en;

    reorder_buffer_ptr_ctrl #(.DEPTH(DEPTH), .TAG_W(TAG_W)) u_ptr (
        .clk      (clk),
        .rst      (rst),
        .rdy      (rdy),
        .do_issue (do_issue),
        .do_commit(do_commit),
        .flush    (mispredict),
        .head     (head),
        .tail     (tail),
        .count    (count),
        .full     (ptr_full),
        .empty    (ptr_empty)
    );

    // Issue, writebacks and commits are all frozen while a flush is in flight.
    assign wb_en = rdy && !flush_pending;

    always_comb begin
        head_ent = ent[head];
`ifdef ROB_WB_BYPASS_EN
        if (rob.alu_wb_valid && rob.alu_wb_rename == head) begin
            head_ent.ready  = 1'b1;
            head_ent.value  = rob.alu_wb_value;
            head_ent.target = rob.alu_wb_target;
        end
        if (rob.lsb_wb_valid && rob.lsb_wb_rename == head) begin
            head_ent.ready = 1'b1;
            head_ent.value = rob.lsb_wb_value;
        end
`endif
        do_commit  = wb_en && !ptr_empty && head_ent.busy && head_ent.ready;
        mispredict = do_commit && is_mispredict(head_ent);
        // A full ROB still accepts an issue when the head retires on the same
        // edge: the freed head slot is the one the tail points at.
        do_issue   = wb_en && rob.issue_valid && !mispredict && (!ptr_full || do_commit);
    end

    assign rob.issue_rename  = tail;
    assign rob.rob_full      = ptr_full || flush_pending;
    assign rob.query_ready_a = ent[rob.query_rename_a].busy && ent[rob.query_rename_a].ready;
    assign rob.query_value_a = ent[rob.query_rename_a].value;
    assign rob.query_ready_b = ent[rob.query_rename_b].busy && ent[rob.query_rename_b].ready;
    assign rob.query_value_b = ent[rob.query_rename_b].value;

    // Entry storage. Later assignments win: LSB over ALU on a shared tag, and
    // a fresh issue over the busy-clear of a slot retiring on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
        end else if (wb_en) begin
            if (rob.alu_wb_valid && ent[rob.alu_wb_rename].busy) begin
                ent[rob.alu_wb_rename].ready  <= 1'b1;
                ent[rob.alu_wb_rename].value  <= rob.alu_wb_value;
                ent[rob.alu_wb_rename].target <= rob.alu_wb_target;
            end
            if (rob.lsb_wb_valid && ent[rob.lsb_wb_rename].busy) begin
                ent[rob.lsb_wb_rename].ready <= 1'b1;
                ent[rob.lsb_wb_rename].value <= rob.lsb_wb_value;
            end
            if (do_commit) ent[head].busy <= 1'b0;
            if (mispredict) begin
                for (int i = 0; i < DEPTH; i++) ent[i].busy <= 1'b0;
            end
            if (do_issue) begin
                ent[tail] <= '{busy: 1'b1, ready: 1'b0, dest: rob.issue_dest,
                               pc: rob.issue_pc, value: '0, target: '0,
                               is_branch: rob.issue_is_branch, is_jalr: rob.issue_is_jalr,
                               pred_jump: rob.issue_pred_jump};
            end
        end
    end

    // Commit and flush outputs. A mispredict edge registers the commit and
    // arms flush_pending; the following edge pulses cdb_flush, and the edge
    // after that drops flush_pending.
    always_ff @(posedge clk) begin
        if (rst) begin
            rob.commit_flag      <= 1'b0;
            rob.commit_value     <= '0;
            rob.commit_rename    <= '0;
            rob.commit_dest      <= '0;
            rob.commit_is_branch <= 1'b0;
            rob.commit_is_jalr   <= 1'b0;
            rob.jalr_next_pc     <= '0;
            rob.cdb_flush        <= 1'b0;
            rob.flush_pc         <= '0;
            flush_pending        <= 1'b0;
        end else if (!rdy) begin
            rob.commit_flag <= 1'b0;
            rob.cdb_flush   <= 1'b0;
        end else begin
            rob.commit_flag <= do_commit;
            if (do_commit) begin
                rob.commit_value     <= head_ent.value;
                rob.commit_rename    <= head;
                rob.commit_dest      <= head_ent.dest;
                rob.commit_is_branch <= head_ent.is_branch;
                rob.commit_is_jalr   <= head_ent.is_jalr;
                rob.jalr_next_pc     <= head_ent.pc + 32'd4;
            end
            if (flush_pending) begin
                rob.cdb_flush <= !rob.cdb_flush;
                if (rob.cdb_flush) flush_pending <= 1'b0;
            end else begin
                rob.cdb_flush <= 1'b0;
                if (mispredict) begin
                    flush_pending <= 1'b1;
                    rob.flush_pc  <= redirect_pc(head_ent);
                end
            end
        end
    end

endmodule
